aes_pipe_sched: RTL and testbench

//  Round-robin scheduler that shares one fully pipelined AES-128 encryptor (aes_top) among NUM_REQ requesters.

---
 rtl/aes_pipe_sched.sv | 132 +++++++++++++
 tb/tb_aes_pipe_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency AES-128 pipeline among NUM_REQ requesters.
// Each block's requester tag travels with the pipeline; credits keep the response FIFO from overflowing.
module aes_pipe_sched #(
  parameter int NUM_REQ    = 4,
  parameter int PIPE_LAT   = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*128-1:0]    req_data,
  input  logic [NUM_REQ*128-1:0]    req_key,
  output logic [127:0]              aes_data_in,
  output logic [127:0]              aes_key,
  input  logic [127:0]              aes_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [127:0]              rsp_data,
  output logic                      busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CNT_W-1:0] outstanding;
  logic [ID_W-1:0]  rr_ptr;
  logic             can_issue;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic             pop;

  logic [ID_W:0]    tag_pipe [PIPE_LAT];
  logic             push;
  logic [ID_W-1:0]  exit_id;

  logic [ID_W+127:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [ID_W+127:0] fifo_head;

  assign can_issue = (outstanding < CNT_W'(FIFO_DEPTH));

  // Search downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
    if (!can_issue || reset) grant_valid = 1'b0;
  end

  assign req_ready = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aes_data_in <= '0;
      aes_key     <= '0;
      rr_ptr      <= '0;
    end else if (grant_valid) begin
      aes_data_in <= req_data[128*grant_id +: 128];
      aes_key     <= req_key[128*grant_id +: 128];
      rr_ptr      <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < PIPE_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= grant_valid ? {1'b1, grant_id} : '0;
      for (int s = 1; s < PIPE_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign push    = tag_pipe[PIPE_LAT-1][ID_W];
  assign exit_id = tag_pipe[PIPE_LAT-1][ID_W-1:0];
  assign pop     = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({grant_valid, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Storage needs no reset; empty-gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {exit_id, aes_result};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (int'(wr_ptr) == FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (int'(rd_ptr) == FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign fifo_head = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_id    = rsp_valid ? fifo_head[ID_W+127:128] : '0;
  assign rsp_data  = rsp_valid ? fifo_head[127:0] : '0;
  assign busy      = (outstanding != '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
                                   !(push && fifo_cnt == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Bench for aes_pipe_sched: a stand-in 12-stage negedge AES pipeline, a queue-based
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_aes_pipe_sched;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [511:0]  req_data;
  logic [511:0]  req_key;
  logic [127:0]  aes_data_in;
  logic [127:0]  aes_key;
  logic [127:0]  aes_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [127:0]  rsp_data;
  logic          busy;

  int errors = 0;
  int checks = 0;

  aes_pipe_sched #(.NUM_REQ(4), .PIPE_LAT(12), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .aes_data_in(aes_data_in), .aes_key(aes_key), .aes_result(aes_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in cipher: the two FIPS-197 vectors are exact, everything else is an arbitrary mix.
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [127:0] key);
    if (key == C1_KEY && pt == C1_PT) return C1_CT;
    if (key == B_KEY && pt == B_PT) return B_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  logic [127:0] aes_pipe [12];
  initial for (int s = 0; s < 12; s++) aes_pipe[s] = '0;
  always @(negedge clk) begin
    for (int s = 11; s > 0; s--) aes_pipe[s] <= aes_pipe[s-1];
    aes_pipe[0] <= cipher(aes_data_in, aes_key);
  end
  assign aes_result = aes_pipe[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: blocks in flight with their due edge, and the response queue.
  typedef struct { int due; logic [1:0] id; logic [127:0] data; } fl_t;
  typedef struct { logic [1:0] id; logic [127:0] data; } rsp_t;
  fl_t  inflight [$];
  rsp_t mfifo [$];
  int           m_out = 0;
  int           m_rr  = 0;
  logic [127:0] m_din = '0;
  logic [127:0] m_key = '0;
  int           edge_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      edge_n++;
      if (reset) begin
        inflight.delete();
        mfifo.delete();
        m_out = 0; m_rr = 0; m_din = '0; m_key = '0;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_aes_data_in", aes_data_in, '0);
      end else begin
        bit         e_gv;
        int         e_g;
        logic [3:0] e_ready;
        bit         e_pop;
        rsp_t       r;
        e_gv = 0; e_g = 0;
        if (m_out < 16)
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (!e_gv && req_valid[idx]) begin e_gv = 1; e_g = idx; end
          end
        e_ready = e_gv ? (4'b0001 << e_g) : 4'b0000;
        chk("req_ready", 128'(req_ready), 128'(e_ready));
        chk("busy", 128'(busy), 128'(m_out != 0));
        chk("aes_data_in", aes_data_in, m_din);
        chk("aes_key", aes_key, m_key);
        chk("rsp_valid", 128'(rsp_valid), 128'(mfifo.size() > 0));
        if (mfifo.size() > 0) begin
          chk("rsp_id", 128'(rsp_id), 128'(mfifo[0].id));
          chk("rsp_data", rsp_data, mfifo[0].data);
        end else begin
          chk("rsp_id_empty", 128'(rsp_id), 128'(0));
          chk("rsp_data_empty", rsp_data, '0);
        end
        e_pop = (mfifo.size() > 0) && rsp_ready;
        if (e_pop) void'(mfifo.pop_front());
        while (inflight.size() > 0 && inflight[0].due == edge_n) begin
          r.id = inflight[0].id; r.data = inflight[0].data;
          mfifo.push_back(r);
          void'(inflight.pop_front());
        end
        if (e_gv) begin
          fl_t f;
          f.due  = edge_n + 12;
          f.id   = 2'(e_g);
          f.data = cipher(req_data[128*e_g +: 128], req_key[128*e_g +: 128]);
          inflight.push_back(f);
          m_din = req_data[128*e_g +: 128];
          m_key = req_key[128*e_g +: 128];
          m_rr  = (e_g + 1) % 4;
        end
        m_out = m_out + int'(e_gv) - int'(e_pop);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("reset_imm_outputs",
        {req_ready, rsp_valid, busy, rsp_id, aes_data_in[7:0], aes_key[7:0]}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: rsp_valid never rose within %0d cycles", name, budget);
    end
  endtask

  initial begin
    bit         ok;
    int         cnt;
    logic [3:0] granted;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    req_data = '0; req_key = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // C.1 vector on requester 0, exact latency
    @(posedge clk); #1;
    req_valid = 4'b0001; req_data[127:0] = C1_PT; req_key[127:0] = C1_KEY;
    @(negedge clk);
    chk("t1_grant", 128'(req_ready), 128'(4'b0001));
    @(posedge clk); #1 req_valid = '0;
    chk("t1_aes_data_in", aes_data_in, C1_PT);
    repeat (12) @(negedge clk);
    chk("t1_not_yet", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    chk("t1_valid", 128'(rsp_valid), 128'(1));
    chk("t1_id", 128'(rsp_id), 128'(0));
    chk("t1_data", rsp_data, C1_CT);

    // fairness with all requesters active
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_key[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("t2_grant", 128'(req_ready), 128'(4'b0001 << (n % 4)));
    end
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("t2_rsp", 20, ok);
    if (ok) begin
      for (int n = 0; n < 8; n++) begin
        if (n > 0) @(negedge clk);
        chk("t2_b2b_valid", 128'(rsp_valid), 128'(1));
        chk("t2_order_id", 128'(rsp_id), 128'(n % 4));
      end
    end

    // backpressure and credit boundary
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[1]) cnt++;
    end
    chk("t3_issues", 128'(cnt), 128'(16));
    chk("t3_ready_low", 128'(req_ready), 128'(0));
    chk("t3_busy", 128'(busy), 128'(1));
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_no_issue_on_pop", 128'(req_ready), 128'(0));
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("t4_issue_after_pop", 128'(req_ready), 128'(4'b0010));
    @(negedge clk);
    chk("t4_full_again", 128'(req_ready), 128'(0));
    chk("t4_busy", 128'(busy), 128'(1));
    @(posedge clk); #1 req_valid = '0;

    // FIPS-197 B vector on requester 2
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100; req_data[256 +: 128] = B_PT; req_key[256 +: 128] = B_KEY;
    @(negedge clk);
    chk("t5_grant", 128'(req_ready), 128'(4'b0100));
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("t5_rsp", 30, ok);
    if (ok) begin
      chk("t5_id", 128'(rsp_id), 128'(2));
      chk("t5_data", rsp_data, B_CT);
    end

    // randomized traffic, held data until granted
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      granted = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || granted[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 40);
          req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
          req_key[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      rsp_ready = ($urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 15 : 80));
    end
    req_valid = '0;

    // reset with blocks in flight
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t6_busy_before", 128'(busy), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_imm_zero", {req_ready, rsp_valid, busy, rsp_id, rsp_data, aes_data_in, aes_key}, '0);
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("t6_no_stale_rsp", 128'(cnt), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
